// File: rtl/bcd_updown_counter_pkg.sv
// Shared definitions for the synchronous multi-digit up/down counter.
// Digit width is fixed; the per-digit modulus is a parameter of each instance.
package bcd_updown_counter_pkg;

  localparam int DW = 4;

  typedef logic [DW-1:0] digit_t;

  function automatic int digit_max(input int radix);
    return radix - 1;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One mod-RADIX digit: loads a sanitised value or steps up/down when told to.
// Neighbour carry/borrow decisions are made by the parent from at_max/at_min.
module bcd_digit
  import bcd_updown_counter_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic   clk,
  input  logic   clear,
  input  logic   step,
  input  logic   up,
  input  logic   load,
  input  digit_t ld_digit,
  output digit_t digit,
  output logic   at_max,
  output logic   at_min,
  output logic   ld_bad
);

  localparam digit_t       MAX_D   = digit_t'(digit_max(RADIX));
  localparam logic [DW:0]  RADIX_W = (DW+1)'(RADIX);

  assign at_max = (digit == MAX_D);
  assign at_min = (digit == '0);
  // Widened compare so RADIX=16 (never illegal) needs no special case
  assign ld_bad = ({1'b0, ld_digit} >= RADIX_W);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      digit <= '0;
    end else if (load) begin
      digit <= ld_bad ? '0 : ld_digit;
    end else if (step) begin
      if (up)
        digit <= at_max ? '0 : digit + digit_t'(1);
      else
        digit <= at_min ? MAX_D : digit - digit_t'(1);
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Synchronous multi-digit up/down counter: all digits update on one edge,
// with carries resolved combinationally, plus cascade tc and status pulses.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] q,
  output logic                 tc,
  output logic                 wrap,
  output logic                 load_err
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] ld_bad;
  logic [DIGITS-1:0] step;

  // Digit i steps when enabled and every lower digit sits at its carry/borrow value
  always_comb begin
    logic run;
    step = '0;
    run  = en;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = run;
      run     = run & (up ? at_max[i] : at_min[i]);
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit #(.RADIX(RADIX)) u_digit (
      .clk      (clk),
      .clear    (clear),
      .step     (step[i]),
      .up       (up),
      .load     (load),
      .ld_digit (load_val[DW*i +: DW]),
      .digit    (q[DW*i +: DW]),
      .at_max   (at_max[i]),
      .at_min   (at_min[i]),
      .ld_bad   (ld_bad[i])
    );
  end

  assign tc = en & (up ? (&at_max) : (&at_min));

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= en & ~load & tc;
      load_err <= load & (|ld_bad);
    end
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised synchronous multi-digit BCD counter; successor to the single-digit mod-10 ripple counter.
- All digits share one clock. Counts up or down, with synchronous load, count enable and a cascade terminal-count output.
- Used for display, timer and event-count datapaths, where ripple skew between digits is not acceptable.

Parameters:
- DIGITS, 4, number of counter digits; legal range 1..8.
- RADIX, 10, modulus of each digit; legal range 2..16 (10 gives BCD).
- DW, 4, bits per digit; fixed as 4, lives in the shared package.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-low reset.
- en  input  1  count enable; also acts as carry-in when counters are cascaded.
- up  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load.
- load_val  input  DIGITS*DW  value to load; digit i is load_val[DW*i +: DW].
- q  output  DIGITS*DW  current count; digit 0 is least significant.
- tc  output  1  terminal count (combinational); drives en of the next stage.
- wrap  output  1  registered one-cycle pulse after the count wraps.
- load_err  output  1  registered one-cycle pulse after a load that contained an illegal digit.

Behaviour:
- Reset (clear=0, asynchronous, takes effect immediately):
  - q=0, wrap=0, load_err=0.
  - Holds while clear is low.
  - Reset mid-count discards any pending update; counting resumes on the first rising edge after clear rises.
- Priority on each clock edge: load > en > hold.
- Load:
  - Each digit takes its load_val digit.
  - Any digit >= RADIX is loaded as 0 instead, and load_err=1 on the next cycle.
  - wrap=0 on a load cycle.
  - en is ignored when load=1.
- Count up (en=1, up=1):
  - Digit i increments when every lower digit equals RADIX-1.
  - A digit at RADIX-1 that increments goes to 0.
  - Digit 0 always steps.
- Count down (en=1, up=0):
  - Digit i decrements when every lower digit equals 0.
  - A digit at 0 that decrements goes to RADIX-1.
- Carries are computed combinationally within one cycle. There is no ripple; all digits update on the same edge, so latency from en to q is 1 cycle.
- tc = en & (up ? all digits == RADIX-1 : all digits == 0). tc is independent of load.
- wrap: set to 1 on the cycle after an edge where en=1, load=0 and tc=1; otherwise 0.
- Direction change: up may change on any cycle. The next step uses the new direction, and there is no dead cycle.
- With en=0 and load=0, q holds and wrap=0.
- Counting can never reach an illegal digit value: load sanitises its input and reset gives 0.
- DIGITS=1 degenerates to a single mod-RADIX counter. tc, wrap and load_err still behave as above.

Decomposition:
- Shared package holds:
  - DW = 4.
  - Function digit_max(RADIX) = RADIX-1.
  - Typedef digit_t = logic [DW-1:0].
- Sub-module bcd_digit (one per digit, via generate):
  - Inputs: clk, clear, step, up, load, ld_digit.
  - Outputs: digit, at_max, at_min, ld_bad.
- Top level computes per-digit step enables from the at_max/at_min chains, and also builds tc, wrap and load_err.

Test Plan:
- Reset: DIGITS=2, drive clear=0 mid-count with q=47 -> q=00 immediately; after clear rises and 3 up-counts, q=03.
- Up wrap: DIGITS=2, load 98, then en=1, up=1 for 3 cycles:
  - q sequence 98 -> 99 -> 00 -> 01.
  - tc=1 only while q=99.
  - wrap=1 only in the cycle where q=00.
- Down borrow: load 10, en=1, up=0 -> q sequence 10 -> 09 -> 08. Then load 00 and count down once -> q=99, wrap=1.
- Load priority and sanitise: load=1, en=1 with load_val=0x3C (digit0=12, illegal) -> q=30, load_err=1 for one cycle, wrap=0.
- Direction flip: q=50, up=1 for one cycle -> 51; then up=0 for two cycles -> 50 -> 49, with no stall.
- Cascade: two DIGITS=1 instances, with the low stage's tc driving the high stage's en:
  - Counting from 00 for 25 cycles -> combined value 25.
  - The high stage steps only on the cycles where the low stage goes 9 -> 0.
